sr_latch_driver: RTL and testbench

Clocked front-end that feeds the NAND set/reset latch stage. It synchronises and debounces two raw request lines, then produces clean active-low set/reset pulses on `S`/`R`. It guarantees that `S` and `R` are never low together, which is the latch's invalid state, and that the latch always returns to hold (`S=R=1`) between pulses. It sits directly upstream of the latch; `S`/`R` wire straight to the latch's inputs.

---
 rtl/sr_latch_driver_pkg.sv | 18 +
 rtl/sr_debounce.sv | 55 +++++
 rtl/sr_latch_driver.sv | 114 +++++++++++
 tb/tb_sr_latch_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch driver.
package sr_latch_driver_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    RST_PULSE = 2'd2,
    GAP       = 2'd3
  } state_e;

  localparam int CONFLICT_W = 8;

  // Bits needed to hold values 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, debounce counter, registered
// rising-edge pulse of the debounced level.
module sr_debounce
  import sr_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The flip happens on the sample that would bring the count to DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Debounced set/reset requests to clean active-low S/R pulses for a NAND latch.
// Optional conflict counter enabled by SR_LATCH_DRIVER_CONFLICT_CNT_EN.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic reset_req,
  output logic S,
  output logic R,
  output logic busy
`ifdef SR_LATCH_DRIVER_CONFLICT_CNT_EN
  ,
  output logic [CONFLICT_W-1:0] conflict_cnt
`endif
);

  localparam int PW = cnt_w(PULSE_CYCLES);
  localparam logic [PW-1:0] PCNT_LOAD = PW'(PULSE_CYCLES - 1);

  logic set_rise, rst_rise;
  logic set_edge, set_want, rst_want;
  logic set_pend_q, set_pend_d, rst_pend_q, rst_pend_d;
  logic s_q, s_d, r_q, r_d, busy_q, busy_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  state_e state_q, state_d;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk(clk), .rst(rst), .raw_i(set_req), .rise_o(set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk(clk), .rst(rst), .raw_i(reset_req), .rise_o(rst_rise)
  );

  // Reset wins a same-cycle conflict: the set edge is discarded outright.
  assign set_edge = set_rise & ~rst_rise;
  assign set_want = set_pend_q | set_edge;
  assign rst_want = rst_pend_q | rst_rise;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    set_pend_d = set_want;
    rst_pend_d = rst_want;
    case (state_q)
      IDLE: begin
        if (rst_want) begin
          state_d    = RST_PULSE;
          pcnt_d     = PCNT_LOAD;
          rst_pend_d = 1'b0;
        end else if (set_want) begin
          state_d    = SET_PULSE;
          pcnt_d     = PCNT_LOAD;
          set_pend_d = 1'b0;
        end
      end
      SET_PULSE, RST_PULSE: begin
        if (pcnt_q == '0) state_d = GAP;
        else              pcnt_d  = pcnt_q - 1'b1;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    s_d    = (state_d != SET_PULSE);
    r_d    = (state_d != RST_PULSE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
      s_q        <= 1'b1;
      r_q        <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
    end
  end

  assign S    = s_q;
  assign R    = r_q;
  assign busy = busy_q;

`ifdef SR_LATCH_DRIVER_CONFLICT_CNT_EN
  logic [CONFLICT_W-1:0] ccnt_q, ccnt_d;

  always_comb begin
    ccnt_d = ccnt_q;
    if (set_rise && rst_rise && (ccnt_q != '1)) ccnt_d = ccnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ccnt_q <= '0;
    else     ccnt_q <= ccnt_d;
  end

  assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a cycle-level behavioural model.
module tb_sr_latch_driver;

  localparam int D = 4;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0;
  logic reset_req = 1'b0;
  logic S, R, busy;
`ifdef SR_LATCH_DRIVER_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sr_latch_driver #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
    .clk(clk),
    .rst(rst),
    .set_req(set_req),
    .reset_req(reset_req),
    .S(S),
    .R(R),
    .busy(busy)
`ifdef SR_LATCH_DRIVER_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: channel 0 = set, 1 = reset. m_rem counts remaining pulse+gap cycles.
  bit m_s1[2], m_s2[2], m_stab[2], m_edge[2], m_pend[2];
  int m_run[2];
  int m_rem = 0;
  int m_kind = 0;
  int m_conf = 0;

  task automatic model_step();
    bit raw, synced;
    cyc++;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_stab[c] = 0; m_edge[c] = 0;
        m_pend[c] = 0; m_run[c] = 0;
      end
      m_rem = 0; m_kind = 0; m_conf = 0;
      return;
    end
    if (m_edge[0] && m_edge[1]) begin
      m_edge[0] = 0;
      if (m_conf < 255) m_conf++;
    end
    for (int c = 0; c < 2; c++) m_pend[c] = m_pend[c] | m_edge[c];
    if (m_rem > 0) m_rem--;
    else if (m_pend[1]) begin m_kind = 1; m_rem = P + 1; m_pend[1] = 0; end
    else if (m_pend[0]) begin m_kind = 0; m_rem = P + 1; m_pend[0] = 0; end
    for (int c = 0; c < 2; c++) begin
      raw = (c == 0) ? set_req : reset_req;
      synced = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw;
      m_edge[c] = 0;
      if (synced != m_stab[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_stab[c] = synced;
          m_run[c] = 0;
          m_edge[c] = synced;
        end
      end else begin
        m_run[c] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  int s_low_n, r_low_n, busy_n, first_s, first_r;
  bit both_low;

  task automatic clear_mon();
    s_low_n = 0; r_low_n = 0; busy_n = 0; first_s = -1; first_r = -1; both_low = 0;
  endtask

  initial forever begin
    bit es, er, eb;
    int ph;
    @(negedge clk);
    es = 1; er = 1; eb = 0;
    if (!rst && m_rem > 0) begin
      eb = 1;
      ph = P + 1 - m_rem;
      if (ph < P) begin
        if (m_kind == 0) es = 0;
        else             er = 0;
      end
    end
    check("S", int'(S), int'(es));
    check("R", int'(R), int'(er));
    check("busy", int'(busy), int'(eb));
`ifdef SR_LATCH_DRIVER_CONFLICT_CNT_EN
    check("conflict_cnt", int'(conflict_cnt), rst ? 0 : m_conf);
`endif
    if (!S) begin s_low_n++; if (first_s < 0) first_s = cyc; end
    if (!R) begin r_low_n++; if (first_r < 0) first_r = cyc; end
    if (busy) busy_n++;
    if (!S && !R) both_low = 1;
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, t1;
    bit seen;
    clear_mon();
    wait_edges(3);
    rst = 0;
    @(negedge clk);
    check("reset_S", int'(S), 1);
    check("reset_R", int'(R), 1);
    check("reset_busy", int'(busy), 0);
`ifdef SR_LATCH_DRIVER_CONFLICT_CNT_EN
    check("reset_conflict", int'(conflict_cnt), 0);
`endif
    wait_edges(1);

    // set request held 10 cycles
    clear_mon(); t0 = cyc;
    set_req = 1; wait_edges(10); set_req = 0; wait_edges(15);
    check("set_first_s", first_s, t0 + 7);
    check("set_s_width", s_low_n, 2);
    check("set_r_quiet", r_low_n, 0);
    check("set_busy_len", busy_n, 3);

    // 3-cycle glitch on reset_req
    clear_mon();
    reset_req = 1; wait_edges(3); reset_req = 0; wait_edges(15);
    check("glitch_s", s_low_n, 0);
    check("glitch_r", r_low_n, 0);
    check("glitch_busy", busy_n, 0);

    // simultaneous requests: reset wins
    clear_mon(); t0 = cyc;
    set_req = 1; reset_req = 1; wait_edges(10);
    set_req = 0; reset_req = 0; wait_edges(15);
    check("simul_s", s_low_n, 0);
    check("simul_r_width", r_low_n, 2);
    check("simul_first_r", first_r, t0 + 7);
`ifdef SR_LATCH_DRIVER_CONFLICT_CNT_EN
    check("simul_conflict", int'(conflict_cnt), 1);
`endif

    // reset edge arrives during the S pulse
    clear_mon(); t0 = cyc;
    set_req = 1; wait_edges(2);
    reset_req = 1; wait_edges(10);
    set_req = 0; reset_req = 0; wait_edges(15);
    check("pend_first_s", first_s, t0 + 7);
    check("pend_first_r", first_r, t0 + 11);
    check("pend_s_width", s_low_n, 2);
    check("pend_r_width", r_low_n, 2);
    check("pend_never_both", int'(both_low), 0);

    // rst asserted on first S=0 cycle, request still held after release
    clear_mon(); t0 = cyc;
    set_req = 1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      wait_edges(1);
      if (!S) seen = 1;
    end
    check("rstmid_s_seen", int'(seen), 1);
    check("rstmid_s_at", cyc, t0 + 7);
    rst = 1; #1;
    check("rstmid_async_S", int'(S), 1);
    check("rstmid_async_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 0; t1 = cyc;
    clear_mon();
    wait_edges(12);
    check("rstmid_relaunch", first_s, t1 + 7);
    check("rstmid_relaunch_w", s_low_n, 2);
    set_req = 0; wait_edges(15);

`ifdef SR_LATCH_DRIVER_CONFLICT_CNT_EN
    // 300 simultaneous edge pairs saturate the counter
    for (int n = 0; n < 300; n++) begin
      set_req = 1; reset_req = 1; wait_edges(8);
      set_req = 0; reset_req = 0; wait_edges(8);
    end
    wait_edges(20);
    check("conflict_sat", int'(conflict_cnt), 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
